ssd_frame_arbiter: RTL

Shares the four seven-segment digits (ssd3..ssd0) among three frame requesters: game status, secret-number reveal and guess-count display. Grants one requester at a time, round-robin. Holds each grant for a fixed number of display ticks, optionally blinking the frame against blank. Sits between the game FSM and the board's segment pins, replacing per-state display muxing in the top level.

---
 rtl/ssd_frame_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ssd_frame_arbiter.sv
// rtl/ssd_frame_arbiter.sv - round-robin arbiter sharing four seven-segment digits among three frame requesters
module ssd_frame_arbiter #(
  parameter int TICK_DIV    = 500000,
  parameter int HOLD_TICKS  = 100,
  parameter int BLINK_TICKS = 25
) (
  input  logic        clk50M,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  blink,
  input  logic [27:0] frame0,
  input  logic [27:0] frame1,
  input  logic [27:0] frame2,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic [6:0]  ssd3,
  output logic [6:0]  ssd2,
  output logic [6:0]  ssd1,
  output logic [6:0]  ssd0
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [27:0]   BLANK      = 28'hFFFFFFF;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        r_state, w_state;
  logic [1:0]    r_ptr, w_ptr;
  logic [1:0]    r_gidx, w_gidx;
  logic [2:0]    r_grant, w_grant;
  logic [2:0]    r_done, w_done;
  logic          r_busy, w_busy;
  logic [PW-1:0] r_presc, w_presc;
  logic [HW-1:0] r_hold, w_hold;
  logic [BW-1:0] r_bcnt, w_bcnt;
  logic          r_phase_blank, w_phase_blank;
  logic          r_blink_en, w_blink_en;
  logic [27:0]   r_ssd, w_ssd;

  logic [1:0]    w_c0, w_c1, w_win;
  logic          w_tick;
  logic          w_gnt_req;
  logic [27:0]   w_frame;

  // Search order after the last winner: ptr+1, ptr+2, ptr (mod 3)
  always_comb begin
    w_c0      = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_c1      = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
    w_win     = req[w_c0] ? w_c0 : (req[w_c1] ? w_c1 : r_ptr);
    w_tick    = (r_presc == PRESC_LAST);
    w_gnt_req = req[r_gidx];
    case (r_gidx)
      2'd0:    w_frame = frame0;
      2'd1:    w_frame = frame1;
      default: w_frame = frame2;
    endcase
  end

  always_comb begin
    w_state       = r_state;
    w_ptr         = r_ptr;
    w_gidx        = r_gidx;
    w_grant       = r_grant;
    w_done        = 3'b000;
    w_busy        = r_busy;
    w_presc       = r_presc;
    w_hold        = r_hold;
    w_bcnt        = r_bcnt;
    w_phase_blank = r_phase_blank;
    w_blink_en    = r_blink_en;
    w_ssd         = (r_state == SHOW && (!r_phase_blank || !r_blink_en)) ? w_frame : BLANK;

    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state       = SHOW;
          w_ptr         = w_win;
          w_gidx        = w_win;
          w_grant       = 3'(3'b001 << w_win);
          w_busy        = 1'b1;
          w_blink_en    = blink[w_win];
          w_presc       = '0;
          w_hold        = '0;
          w_bcnt        = '0;
          w_phase_blank = 1'b0;
        end
      end
      SHOW: begin
        // A dropped request beats a coinciding final tick: no done pulse
        if (!w_gnt_req) begin
          w_state = GAP;
          w_grant = 3'b000;
          w_busy  = 1'b0;
        end else if (w_tick && r_hold == HOLD_LAST) begin
          w_state = GAP;
          w_grant = 3'b000;
          w_busy  = 1'b0;
          w_done  = r_grant;
        end else begin
          w_presc = w_tick ? '0 : r_presc + PW'(1);
          if (w_tick) begin
            w_hold = r_hold + HW'(1);
            if (r_blink_en) begin
              if (r_bcnt == BLINK_LAST) begin
                w_bcnt        = '0;
                w_phase_blank = ~r_phase_blank;
              end else begin
                w_bcnt = r_bcnt + BW'(1);
              end
            end
          end
        end
      end
      GAP:     w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ptr         <= 2'd2;
      r_gidx        <= 2'd0;
      r_grant       <= 3'b000;
      r_done        <= 3'b000;
      r_busy        <= 1'b0;
      r_presc       <= '0;
      r_hold        <= '0;
      r_bcnt        <= '0;
      r_phase_blank <= 1'b0;
      r_blink_en    <= 1'b0;
      r_ssd         <= BLANK;
    end else begin
      r_state       <= w_state;
      r_ptr         <= w_ptr;
      r_gidx        <= w_gidx;
      r_grant       <= w_grant;
      r_done        <= w_done;
      r_busy        <= w_busy;
      r_presc       <= w_presc;
      r_hold        <= w_hold;
      r_bcnt        <= w_bcnt;
      r_phase_blank <= w_phase_blank;
      r_blink_en    <= w_blink_en;
      r_ssd         <= w_ssd;
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;
  assign ssd3  = r_ssd[27:21];
  assign ssd2  = r_ssd[20:14];
  assign ssd1  = r_ssd[13:7];
  assign ssd0  = r_ssd[6:0];

endmodule
